// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Schedules one pipelined radix-2 butterfly through every stage of an in-place
// decimation-in-time FFT. It produces the read addresses, the twiddle index
// and the butterfly valid strobe, plus write-back addresses delayed to line up
// with the butterfly outputs. A single stall input freezes the whole schedule.
module fft_stage_sequencer #(
  parameter int N_LOG2       = 8,
  parameter int BFLY_LATENCY = 3,
  parameter int RD_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_LOG2)-1:0] stage,
  output logic                      rd_en,
  output logic [N_LOG2-1:0]         rd_addr_a,
  output logic [N_LOG2-1:0]         rd_addr_b,
  output logic [N_LOG2-2:0]         tw_addr,
  output logic                      bfly_en,
  output logic                      bfly_valid_in,
  output logic                      wr_en,
  output logic [N_LOG2-1:0]         wr_addr_a,
  output logic [N_LOG2-1:0]         wr_addr_b
);

  // Read-to-write distance: RAM read latency plus butterfly latency.
  localparam int D  = RD_LATENCY + BFLY_LATENCY;
  localparam int SW = $clog2(N_LOG2);
  localparam int JW = N_LOG2 - 1;
  localparam int CW = $clog2(D + 1);

  localparam logic [JW-1:0] J_LAST     = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            rd_en_q, rd_en_d;
  logic [N_LOG2-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [N_LOG2-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [JW-1:0]   tw_addr_q, tw_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bfly_valid_q, bfly_valid_d;

  logic              wr_en_pipe_q [D];
  logic              wr_en_pipe_d [D];
  logic [N_LOG2-1:0] wr_a_pipe_q  [D];
  logic [N_LOG2-1:0] wr_a_pipe_d  [D];
  logic [N_LOG2-1:0] wr_b_pipe_q  [D];
  logic [N_LOG2-1:0] wr_b_pipe_d  [D];

  logic [N_LOG2-1:0] span_mask;
  logic [N_LOG2-1:0] j_ext;
  logic [3:0]        tw_shift;

  // State register; stall freezes the schedule in place.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (!stall) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: butterfly counter j, stage index and drain counter.
  // NOTE: every signal gets a default at the top of a combinational block, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        if (j_q == J_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + SW'(1);
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with
  // the state they describe. Addresses hold their last value outside RUN.
  always_comb begin
    // Inserting a zero bit at position 'stage' into j gives grp*2*span + pos;
    // partner b then differs only in that bit, so OR is the same as + span.
    span_mask = (N_LOG2'(1) << stage_d) - N_LOG2'(1);
    j_ext     = {1'b0, j_d};
    tw_shift  = 4'(JW) - 4'(stage_d);

    rd_en_d      = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    bfly_valid_d = rd_en_q;
    rd_addr_a_d  = rd_addr_a_q;
    rd_addr_b_d  = rd_addr_b_q;
    tw_addr_d    = tw_addr_q;
    if (rd_en_d) begin
      rd_addr_a_d = ((j_ext & ~span_mask) << 1) | (j_ext & span_mask);
      rd_addr_b_d = rd_addr_a_d | (N_LOG2'(1) << stage_d);
      tw_addr_d   = (j_d & span_mask[JW-1:0]) << tw_shift;
    end
  end

  // Counters and registered read-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q          <= '0;
      stage_q      <= '0;
      cnt_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_a_q  <= '0;
      rd_addr_b_q  <= '0;
      tw_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bfly_valid_q <= 1'b0;
    end else if (!stall) begin
      j_q          <= j_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      rd_en_q      <= rd_en_d;
      rd_addr_a_q  <= rd_addr_a_d;
      rd_addr_b_q  <= rd_addr_b_d;
      tw_addr_q    <= tw_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bfly_valid_q <= bfly_valid_d;
    end
  end

  // Write-back shift pipe: read strobe and addresses delayed by D cycles.
  always_comb begin
    wr_en_pipe_d[0] = rd_en_q;
    wr_a_pipe_d[0]  = rd_addr_a_q;
    wr_b_pipe_d[0]  = rd_addr_b_q;
    for (int i = 1; i < D; i++) begin
      wr_en_pipe_d[i] = wr_en_pipe_q[i-1];
      wr_a_pipe_d[i]  = wr_a_pipe_q[i-1];
      wr_b_pipe_d[i]  = wr_b_pipe_q[i-1];
    end
  end

  // Pipe registers advance only on unstalled cycles.
  // NOTE: the pipe storage is reset too, because a reset mid-transform must not
  // let stale write strobes leak out after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        wr_en_pipe_q[i] <= 1'b0;
        wr_a_pipe_q[i]  <= '0;
        wr_b_pipe_q[i]  <= '0;
      end
    end else if (!stall) begin
      for (int i = 0; i < D; i++) begin
        wr_en_pipe_q[i] <= wr_en_pipe_d[i];
        wr_a_pipe_q[i]  <= wr_a_pipe_d[i];
        wr_b_pipe_q[i]  <= wr_b_pipe_d[i];
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign stage         = stage_q;
  assign rd_en         = rd_en_q;
  assign rd_addr_a     = rd_addr_a_q;
  assign rd_addr_b     = rd_addr_b_q;
  assign tw_addr       = tw_addr_q;
  assign bfly_en       = ~stall;
  assign bfly_valid_in = bfly_valid_q;
  assign wr_en         = wr_en_pipe_q[D-1];
  assign wr_addr_a     = wr_a_pipe_q[D-1];
  assign wr_addr_b     = wr_b_pipe_q[D-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: a small (N_LOG2=3) and a default (N_LOG2=8)
// instance share the clock and reset; 'sel' routes start/stall to one of them
// and picks which one is observed. Expected values come from a timing model
// written directly from the per-stage period arithmetic.
module tb_fft_stage_sequencer;

  localparam int BL        = 3;
  localparam int D         = 1 + BL;
  localparam int MAX_PRINT = 30;

  logic clk = 1'b0;
  logic rst, start, stall, sel;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance
  logic       s_busy, s_done, s_rd_en, s_bfly_en, s_bv, s_wr_en;
  logic [1:0] s_stage, s_tw;
  logic [2:0] s_rd_a, s_rd_b, s_wr_a, s_wr_b;
  // Default-size instance
  logic       l_busy, l_done, l_rd_en, l_bfly_en, l_bv, l_wr_en;
  logic [2:0] l_stage;
  logic [6:0] l_tw;
  logic [7:0] l_rd_a, l_rd_b, l_wr_a, l_wr_b;

  logic s_start, s_stall, l_start, l_stall;
  assign s_start = start & ~sel;
  assign s_stall = stall & ~sel;
  assign l_start = start & sel;
  assign l_stall = stall & sel;

  fft_stage_sequencer #(.N_LOG2(3), .BFLY_LATENCY(BL), .RD_LATENCY(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .stall(s_stall),
    .busy(s_busy), .done(s_done), .stage(s_stage),
    .rd_en(s_rd_en), .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b), .tw_addr(s_tw),
    .bfly_en(s_bfly_en), .bfly_valid_in(s_bv),
    .wr_en(s_wr_en), .wr_addr_a(s_wr_a), .wr_addr_b(s_wr_b)
  );

  fft_stage_sequencer #(.N_LOG2(8), .BFLY_LATENCY(BL), .RD_LATENCY(1)) dut_l (
    .clk(clk), .rst(rst), .start(l_start), .stall(l_stall),
    .busy(l_busy), .done(l_done), .stage(l_stage),
    .rd_en(l_rd_en), .rd_addr_a(l_rd_a), .rd_addr_b(l_rd_b), .tw_addr(l_tw),
    .bfly_en(l_bfly_en), .bfly_valid_in(l_bv),
    .wr_en(l_wr_en), .wr_addr_a(l_wr_a), .wr_addr_b(l_wr_b)
  );

  // Observed view of the selected instance, zero-extended.
  logic        o_busy, o_done, o_rd_en, o_bfly_en, o_bv, o_wr_en;
  logic [3:0]  o_stage;
  logic [11:0] o_rd_a, o_rd_b, o_tw, o_wr_a, o_wr_b;
  assign o_busy    = sel ? l_busy    : s_busy;
  assign o_done    = sel ? l_done    : s_done;
  assign o_rd_en   = sel ? l_rd_en   : s_rd_en;
  assign o_bfly_en = sel ? l_bfly_en : s_bfly_en;
  assign o_bv      = sel ? l_bv      : s_bv;
  assign o_wr_en   = sel ? l_wr_en   : s_wr_en;
  assign o_stage   = sel ? 4'(l_stage) : 4'(s_stage);
  assign o_rd_a    = sel ? 12'(l_rd_a) : 12'(s_rd_a);
  assign o_rd_b    = sel ? 12'(l_rd_b) : 12'(s_rd_b);
  assign o_tw      = sel ? 12'(l_tw)   : 12'(s_tw);
  assign o_wr_a    = sel ? 12'(l_wr_a) : 12'(s_wr_a);
  assign o_wr_b    = sel ? 12'(l_wr_b) : 12'(s_wr_b);

  typedef struct packed {
    logic        busy, done, rd_en, bv, wr_en;
    logic [3:0]  stage;
    logic [11:0] rd_a, rd_b, tw, wr_a, wr_b;
  } exp_t;

  logic [35:0] rd_log[$];
  logic [24:0] hist[int];

  // Butterfly j of stage s, straight from the DIT indexing rules.
  function automatic void bfly(input int nl, input int s, input int j,
                               output logic [11:0] a, output logic [11:0] b,
                               output logic [11:0] tw);
    int span, grp, pos;
    span = 1 << s;
    grp  = j / span;
    pos  = j % span;
    a    = 12'(grp * 2 * span + pos);
    b    = 12'(grp * 2 * span + pos + span);
    tw   = 12'(pos * (1 << (nl - 1 - s)));
  endfunction

  // Expected outputs after k unstalled edges counted from the start edge.
  function automatic exp_t model(input int nl, input int k);
    int   half, p, s, r;
    exp_t e;
    e    = '0;
    half = 1 << (nl - 1);
    p    = half + D;
    e.busy = (k >= 1 && k <= nl * p + 1);
    e.done = (k == nl * p + 1);
    if (k >= 1 && k <= nl * p) begin
      s       = (k - 1) / p;
      r       = (k - 1) % p;
      e.stage = 4'(s);
      e.rd_en = (r < half);
      e.bv    = (r >= 1 && r <= half);
      e.wr_en = (r >= D);
      if (e.rd_en) bfly(nl, s, r, e.rd_a, e.rd_b, e.tw);
      if (e.wr_en) begin
        logic [11:0] unused_tw;
        bfly(nl, s, r - D, e.wr_a, e.wr_b, unused_tw);
      end
    end
    return e;
  endfunction

  // Runs one full transform on the selected instance, checking every cycle.
  // Must be entered just after a negedge with the instance idle.
  task automatic run_transform(input string name, input bit big, input int stall_k,
                               input int stall_len, input int rand_pct, input bit poke,
                               output int done_at);
    int   nl, half, p, last_k, k, stall_left, done_cnt, wr_cnt, seen_stage, c0;
    int   wr_per_stage[12];
    logic applied;
    exp_t e;
    nl = big ? 8 : 3;
    half = 1 << (nl - 1);
    p = half + D;
    last_k = nl * p + 1;
    sel = big;
    start = 1'b1;
    stall = 1'b0;
    applied = 1'b0;
    k = 0;
    stall_left = -1;
    done_cnt = 0;
    wr_cnt = 0;
    seen_stage = 0;
    done_at = -1;
    c0 = cyc;
    foreach (wr_per_stage[i]) wr_per_stage[i] = 0;
    rd_log.delete();
    hist.delete();
    for (int step = 0; step < 5000; step++) begin
      @(negedge clk);
      if (!applied) k++;
      start = poke && k >= 2 && k < last_k - 1 && ($urandom_range(0, 2) == 0);
      e = model(nl, k);

      checks++;
      if ({o_busy, o_done, o_rd_en, o_bv, o_wr_en, o_bfly_en} !==
          {e.busy, e.done, e.rd_en, e.bv, e.wr_en, ~applied}) begin
        errors++;
        if (errors <= MAX_PRINT)
          $display("FAIL %s ctrl k=%0d busy/done/rd/bv/wr/bfly_en got=%b exp=%b", name, k,
                   {o_busy, o_done, o_rd_en, o_bv, o_wr_en, o_bfly_en},
                   {e.busy, e.done, e.rd_en, e.bv, e.wr_en, ~applied});
      end
      if (e.rd_en) begin
        checks++;
        if ({o_rd_a, o_rd_b, o_tw} !== {e.rd_a, e.rd_b, e.tw}) begin
          errors++;
          if (errors <= MAX_PRINT)
            $display("FAIL %s rd k=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d", name, k,
                     o_rd_a, o_rd_b, o_tw, e.rd_a, e.rd_b, e.tw);
        end
      end
      if (e.wr_en) begin
        checks++;
        if ({o_wr_a, o_wr_b} !== {e.wr_a, e.wr_b} ||
            !hist.exists(k - D) || hist[k - D] !== {1'b1, o_wr_a, o_wr_b}) begin
          errors++;
          if (errors <= MAX_PRINT)
            $display("FAIL %s wr k=%0d got a=%0d b=%0d exp a=%0d b=%0d", name, k,
                     o_wr_a, o_wr_b, e.wr_a, e.wr_b);
        end
      end
      if (e.busy && !e.done) begin
        checks++;
        if (o_stage !== e.stage) begin
          errors++;
          if (errors <= MAX_PRINT)
            $display("FAIL %s stage k=%0d got=%0d exp=%0d", name, k, o_stage, e.stage);
        end
      end

      if (!applied) begin
        hist[k] = {o_rd_en, o_rd_a[11:0], o_rd_b[11:0]};
        if (o_rd_en) rd_log.push_back({o_rd_a, o_rd_b, o_tw});
        if (o_rd_en && int'(o_stage) > seen_stage) begin
          seen_stage = int'(o_stage);
          checks++;
          if (wr_cnt !== seen_stage * half) begin
            errors++;
            if (errors <= MAX_PRINT)
              $display("FAIL %s read_before_write stage=%0d writes_done=%0d need=%0d", name,
                       seen_stage, wr_cnt, seen_stage * half);
          end
        end
        if (o_wr_en) begin
          wr_cnt++;
          if (k >= 1 && (k - 1) / p < 12) wr_per_stage[(k - 1) / p]++;
        end
        if (o_done) begin
          done_cnt++;
          done_at = cyc - c0;
        end
      end

      if (k == last_k + 1) break;

      if (k == stall_k && stall_left < 0) stall_left = stall_len;
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = (rand_pct > 0) && ($urandom_range(0, 99) < rand_pct);
      end
      applied = stall;
    end
    stall = 1'b0;
    start = 1'b0;

    checks++;
    if (k != last_k + 1) begin
      errors++;
      $display("FAIL %s timeout reached k=%0d need=%0d", name, k, last_k + 1);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
    end
    checks++;
    if (wr_cnt != nl * half) begin
      errors++;
      $display("FAIL %s total_writes got=%0d exp=%0d", name, wr_cnt, nl * half);
    end
    for (int s = 0; s < nl; s++) begin
      checks++;
      if (wr_per_stage[s] != half) begin
        errors++;
        $display("FAIL %s writes_stage%0d got=%0d exp=%0d", name, s, wr_per_stage[s], half);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      checks++;
      if ({o_busy, o_done, o_rd_en, o_bv, o_wr_en, o_stage, o_rd_a, o_rd_b, o_tw, o_wr_a, o_wr_b} !== '0
          || o_bfly_en !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold sel=%0d busy=%b rd_en=%b wr_en=%b bfly_en=%b exp all 0 bfly_en=1",
                 i, o_busy, o_rd_en, o_wr_en, o_bfly_en);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        sel = i[0];
        #1;
        checks++;
        if ({o_busy, o_done, o_rd_en, o_bv, o_wr_en, o_stage, o_rd_a, o_rd_b, o_tw, o_wr_a, o_wr_b} !== '0
            || o_bfly_en !== 1'b1) begin
          errors++;
          $display("FAIL reset_idle c=%0d sel=%0d busy=%b rd_en=%b wr_en=%b bfly_en=%b exp all 0 bfly_en=1",
                   c, i, o_busy, o_rd_en, o_wr_en, o_bfly_en);
        end
      end
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_schedule();
    int d;
    int tbl[36];
    tbl = '{0,1,0, 2,3,0, 4,5,0, 6,7,0,
            0,2,0, 1,3,2, 4,6,0, 5,7,2,
            0,4,0, 1,5,1, 2,6,2, 3,7,3};
    run_transform("small", 1'b0, -1, 0, 0, 1'b0, d);
    checks++;
    if (d != 25) begin
      errors++;
      $display("FAIL small_done_cycle got=c0+%0d exp=c0+25", d);
    end
    checks++;
    if (rd_log.size() != 12) begin
      errors++;
      $display("FAIL small_read_count got=%0d exp=12", rd_log.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rd_log[i] !== {12'(tbl[3*i]), 12'(tbl[3*i+1]), 12'(tbl[3*i+2])}) begin
          errors++;
          $display("FAIL small_table idx=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d", i,
                   rd_log[i][35:24], rd_log[i][23:12], rd_log[i][11:0],
                   tbl[3*i], tbl[3*i+1], tbl[3*i+2]);
        end
      end
    end
  endtask

  task automatic test_write_alignment();
    int d;
    run_transform("default", 1'b1, -1, 0, 0, 1'b0, d);
    checks++;
    if (d != 8 * (128 + D) + 1) begin
      errors++;
      $display("FAIL default_done_cycle got=c0+%0d exp=c0+%0d", d, 8 * (128 + D) + 1);
    end
  endtask

  task automatic test_stall();
    int d;
    run_transform("stall5", 1'b0, (4 + D) + 3, 5, 0, 1'b0, d);
    checks++;
    if (d != 30) begin
      errors++;
      $display("FAIL stall_done_cycle got=c0+%0d exp=c0+30", d);
    end
  endtask

  task automatic test_random_stall();
    int d;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_transform("rand_small", 1'b0, -1, 0, 30, 1'b0, d);
    end
    run_transform("rand_default", 1'b1, -1, 0, 15, 1'b0, d);
  endtask

  task automatic test_start_while_busy();
    int d;
    run_transform("poke", 1'b0, -1, 0, 0, 1'b1, d);
    checks++;
    if (d != 25) begin
      errors++;
      $display("FAIL poke_done_cycle got=c0+%0d exp=c0+25", d);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [35:0] first_log[$];
    run_transform("b2b_first", 1'b0, -1, 0, 0, 1'b0, d1);
    first_log = rd_log;
    run_transform("b2b_second", 1'b0, -1, 0, 0, 1'b0, d2);
    checks++;
    if (d2 != 25) begin
      errors++;
      $display("FAIL b2b_done_cycle got=c0+%0d exp=c0+25", d2);
    end
    checks++;
    if (rd_log.size() != first_log.size() || rd_log != first_log) begin
      errors++;
      $display("FAIL b2b_sequence got_len=%0d exp_len=%0d (sequences differ)",
               rd_log.size(), first_log.size());
    end
  endtask

  task automatic test_reset_mid();
    int  d;
    bit  reached;
    sel = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (o_stage == 4'd2 && o_rd_en) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reset_mid_reach_stage2 got stage=%0d exp=2", o_stage);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_rd_en, o_bv, o_wr_en, o_stage, o_rd_a, o_rd_b, o_tw, o_wr_a, o_wr_b} !== '0
        || o_bfly_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async busy=%b rd_en=%b wr_en=%b stage=%0d bfly_en=%b exp all 0 bfly_en=1",
               o_busy, o_rd_en, o_wr_en, o_stage, o_bfly_en);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_transform("after_reset", 1'b0, -1, 0, 0, 1'b0, d);
    checks++;
    if (d != 25) begin
      errors++;
      $display("FAIL after_reset_done_cycle got=c0+%0d exp=c0+25", d);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;
    test_reset();
    test_small_schedule();
    test_write_alignment();
    test_stall();
    test_random_stall();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
